// File: rtl/swo_pkg.sv
// swo_pkg: shared types for the SWO Manchester receiver.
// Decoder states and per-cycle sample classification.
package swo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HBLEN,
    BIT0,
    BIT1
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    EDGE_PRE,
    EDGE_MID,
    GLITCH
  } smp_t;

  function automatic smp_t classify(
    input logic o,
    input logic a,
    input logic b
  );
    smp_t c;
    unique case (1'b1)
      (o != a) && (a == b): c = EDGE_PRE;
      (o == a) && (a != b): c = EDGE_MID;
      (o != a) && (a != b): c = GLITCH;
      default:              c = NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/swo_byte_fifo.sv
// swo_byte_fifo: small synchronous FIFO.
// A pop frees the head slot before a same-cycle push lands.
module swo_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_pop;
  logic             do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  // pointer update; push and pop may both fire
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // storage, cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (do_push) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/swo_manch_rx.sv
// swo_manch_rx: Manchester SWO receiver, two samples per clock.
// Half-bit length is learnt from each packet's start bit.
module swo_manch_rx #(
  parameter int CNT_W      = 17,
  parameter int EOP_SHIFT  = 3,
  parameter int MIN_HBLEN  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SWOina,
  input  logic             SWOinb,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pkt_end,
  output logic             frame_err,
  output logic             overflow,
  output logic             glitch,
  output logic             in_packet,
  output logic [CNT_W-1:0] halfbit_len
);

  import swo_pkg::*;

  localparam int W2 = CNT_W + 2;
  localparam int TW = CNT_W + EOP_SHIFT + 1;

  state_t           state, state_n;
  smp_t             cls;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hlen, hlen_n;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] closed_s;
  logic [CNT_W-1:0] newrun;
  logic [CNT_W:0]   sum2;
  logic [CNT_W:0]   closed_w;
  logic [2:0]       bitcnt, bitcnt_n;
  logic [7:0]       cons, cons_n;
  logic [W2-1:0]    run2, hx, h3, h5;
  logic [TW-1:0]    tlim;
  logic             old, edge_s;
  logic             run_short, run_over, tmo;
  logic             push, pop, drop;
  logic             full, empty;
  logic             glitch_d, ferr_d, pend_d;

  assign cls    = classify(old, SWOina, SWOinb);
  assign edge_s = (cls == EDGE_PRE) ||
                  (cls == EDGE_MID);

  assign sum2     = {1'b0, cnt} + (CNT_W+1)'(2);
  assign cnt_inc  = sum2[CNT_W] ? '1
                  : sum2[CNT_W-1:0];
  assign closed_w = {1'b0, cnt} +
                    {{CNT_W{1'b0}}, cls == EDGE_MID};
  assign closed_s = closed_w[CNT_W] ? '1
                  : closed_w[CNT_W-1:0];
  assign newrun   = (cls == EDGE_PRE) ? CNT_W'(2)
                  : CNT_W'(1);

  assign run2 = {closed_w, 1'b0};
  assign hx   = W2'(hlen);
  assign h3   = hx + (hx << 1);
  assign h5   = hx + (hx << 2);
  assign run_short = run2 < h3;
  assign run_over  = run2 > h5;

  assign tlim = TW'(hlen) << EOP_SHIFT;
  assign tmo  = TW'(cnt_inc) > tlim;

  // decoder next state, run counter and byte assembly
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hlen_n   = hlen;
    bitcnt_n = bitcnt;
    cons_n   = cons;
    push     = 1'b0;
    glitch_d = 1'b0;
    ferr_d   = 1'b0;
    pend_d   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (edge_s && SWOinb) begin
          cnt_n   = newrun;
          state_n = HBLEN;
        end
      end
      HBLEN: begin
        cnt_n = cnt_inc;
        if (edge_s) begin
          if (closed_w < (CNT_W+1)'(MIN_HBLEN)) begin
            glitch_d = 1'b1;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            hlen_n   = closed_s;
            bitcnt_n = '0;
            cnt_n    = newrun;
            state_n  = BIT0;
          end
        end
      end
      BIT0, BIT1: begin
        cnt_n = cnt_inc;
        if (edge_s) begin
          cnt_n = newrun;
          if (run_over ||
              (state == BIT1 && !run_short)) begin
            ferr_d  = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else if (state == BIT0 && run_short) begin
            state_n = BIT1;
          end else begin
            cons_n[bitcnt] = old;
            push     = (bitcnt == 3'd7);
            bitcnt_n = bitcnt + 3'd1;
            state_n  = BIT0;
          end
        end else if (tmo) begin
          pend_d  = (bitcnt == 3'd0);
          ferr_d  = (bitcnt != 3'd0);
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // decoder state and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hlen      <= '0;
      bitcnt    <= '0;
      cons      <= '0;
      old       <= 1'b0;
      glitch    <= 1'b0;
      frame_err <= 1'b0;
      pkt_end   <= 1'b0;
      overflow  <= 1'b0;
      in_packet <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hlen      <= hlen_n;
      bitcnt    <= bitcnt_n;
      cons      <= cons_n;
      old       <= SWOinb;
      glitch    <= glitch_d;
      frame_err <= ferr_d;
      pkt_end   <= pend_d;
      overflow  <= drop;
      in_packet <= (state_n != IDLE);
    end
  end

  assign halfbit_len = hlen;
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;
  assign drop        = push && full && !pop;

  swo_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cons_n),
    .pop   (pop),
    .dout  (out_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_swo_manch_rx.sv
// tb_swo_manch_rx: scoreboard bench for swo_manch_rx.
// Builds Manchester sample streams and checks bytes and events.
module tb_swo_manch_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SWOina = 1'b0;
  logic        SWOinb = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        pkt_end, frame_err;
  logic        overflow, glitch;
  logic        in_packet;
  logic [16:0] halfbit_len;

  int checks = 0;
  int failures = 0;
  int n_pend = 0, n_ferr = 0;
  int n_ovf = 0, n_glt = 0;
  int p0, f0, o0, g0;

  logic [7:0] exp_q [$];
  logic       smp [$];
  logic [7:0] pb [0:7];

  swo_manch_rx #(
    .CNT_W      (17),
    .EOP_SHIFT  (3),
    .MIN_HBLEN  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .SWOina      (SWOina),
    .SWOinb      (SWOinb),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pkt_end     (pkt_end),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .glitch      (glitch),
    .in_packet   (in_packet),
    .halfbit_len (halfbit_len)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pkt_end)   n_pend++;
    if (frame_err) n_ferr++;
    if (overflow)  n_ovf++;
    if (glitch)    n_glt++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0)
        chk("extra_byte", exp_q.size(), 1);
      else
        chk("byte", out_data, exp_q.pop_front());
    end
  end

  task automatic add(input logic v, input int n);
    repeat (n) smp.push_back(v);
  endtask

  task automatic build(
    input int h,
    input int nbits,
    input int tail
  );
    logic bv;
    add(1'b0, 8);
    add(1'b1, h);
    add(1'b0, h);
    for (int i = 0; i < nbits; i++) begin
      bv = pb[i/8][i%8];
      if (bv) begin
        add(1'b1, h);
        add(1'b0, h);
      end else begin
        add(1'b0, h);
        add(1'b1, h);
      end
    end
    add(1'b0, tail);
    if (smp.size() % 2 != 0) add(smp[$], 1);
  endtask

  task automatic play();
    while (smp.size() > 0) begin
      @(posedge clk);
      #1;
      SWOina = smp.pop_front();
      SWOinb = smp.pop_front();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      SWOina = 1'b0;
      SWOinb = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++)
      idle(1);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_hlen", halfbit_len, 0);
    chk("rst_inpkt", in_packet, 0);
    chk("rst_pulses",
        {pkt_end, frame_err, overflow, glitch}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    idle(4);

    out_ready = 1'b1;
    p0 = n_pend; f0 = n_ferr;
    pb[0] = 8'h5A;
    exp_q.push_back(8'h5A);
    build(4, 8, 48);
    play();
    idle(4);
    chk("t1_hlen", halfbit_len, 4);
    chk("t1_pend", n_pend - p0, 1);
    chk("t1_ferr", n_ferr - f0, 0);
    chk("t1_q", exp_q.size(), 0);
    chk("t1_inpkt", in_packet, 0);

    p0 = n_pend; f0 = n_ferr;
    o0 = n_ovf; g0 = n_glt;
    pb[0] = 8'h00; pb[1] = 8'hFF; pb[2] = 8'hA5;
    for (int i = 0; i < 3; i++) exp_q.push_back(pb[i]);
    build(4, 24, 48);
    play();
    idle(4);
    chk("t2_pend", n_pend - p0, 1);
    chk("t2_err",
        (n_ferr - f0) + (n_ovf - o0) + (n_glt - g0), 0);
    chk("t2_q", exp_q.size(), 0);

    out_ready = 1'b0;
    o0 = n_ovf; p0 = n_pend;
    for (int i = 0; i < 6; i++) pb[i] = 8'((i+1) * 17);
    for (int i = 0; i < 4; i++) exp_q.push_back(pb[i]);
    build(4, 48, 48);
    play();
    idle(4);
    chk("t3_ovf", n_ovf - o0, 2);
    chk("t3_valid", out_valid, 1);
    chk("t3_pend", n_pend - p0, 1);
    out_ready = 1'b1;
    drain();
    idle(2);
    chk("t3_empty", out_valid, 0);

    g0 = n_glt;
    add(1'b0, 9);
    add(1'b1, 1);
    add(1'b0, 10);
    play();
    idle(3);
    chk("t4_glitch", n_glt - g0, 1);
    chk("t4_inpkt", in_packet, 0);
    pb[0] = 8'h96;
    exp_q.push_back(8'h96);
    build(4, 8, 48);
    play();
    idle(4);
    drain();
    chk("t4_hlen", halfbit_len, 4);

    f0 = n_ferr; p0 = n_pend;
    pb[0] = 8'h05;
    build(4, 3, 48);
    play();
    idle(4);
    chk("t5_ferr", n_ferr - f0, 1);
    chk("t5_pend", n_pend - p0, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_inpkt", in_packet, 0);

    out_ready = 1'b0;
    pb[0] = 8'h3C; pb[1] = 8'hF0;
    build(4, 12, 0);
    play();
    chk("t6_inpkt", in_packet, 1);
    chk("t6_held", out_valid, 1);
    SWOina = 1'b0;
    SWOinb = 1'b0;
    rst = 1'b1;
    f0 = n_ferr; p0 = n_pend;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    idle(6);
    chk("t6_nopulse", (n_ferr - f0) + (n_pend - p0), 0);
    out_ready = 1'b1;
    pb[0] = 8'hC3;
    exp_q.push_back(8'hC3);
    build(6, 8, 72);
    play();
    idle(4);
    drain();
    chk("t6_hlen", halfbit_len, 6);
    chk("t6_pend", n_pend - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
